// File: rtl/stdcore_ubfifo_rdctl_pkg.sv
// rtl/stdcore_ubfifo_rdctl_pkg.sv - shared types and helpers for the unified-block FIFO read controller
package stdcore_ubfifo_rdctl_pkg;

  localparam int DEF_UB_SIZE       = 64;
  localparam int DEF_UNIT          = 4;
  localparam int DEF_UB_UNITS_LOG2 = $clog2(DEF_UB_SIZE / DEF_UNIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_NEXT,
    ST_FLUSH
  } rd_state_e;

  function automatic logic [12:0] ceil_div_unit(input logic [12:0] n, input int unsigned unit_log2);
    logic [12:0] round_up;
    round_up = (13'd1 << unit_log2) - 13'd1;
    return (n + round_up) >> unit_log2;
  endfunction

endpackage

// File: rtl/stdcore_skid2.sv
// rtl/stdcore_skid2.sv - two-entry output buffer with a read-credit check
module stdcore_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         in_flight,
  input  logic         pop_ready,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         credit
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   occ;
  logic         pop;

  assign head_valid = (occ != 2'd0);
  assign pop        = head_valid & pop_ready;
  assign head_data  = mem[rd_ptr];
  // A read in flight already owns a slot, so it counts against the two entries.
  assign credit     = (({1'b0, occ} + {2'b00, in_flight}) < 3'd2) || pop;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/stdcore_ubfifo_rdctl.sv
// rtl/stdcore_ubfifo_rdctl.sv - raster tile walker that reads unified blocks out of the FIFO
module stdcore_ubfifo_rdctl
  import stdcore_ubfifo_rdctl_pkg::*;
#(
  parameter int DW     = 1,
  parameter int AW     = 1,
  parameter int ubSize = 64,
  parameter int unit   = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          start,
  input  logic [12:0]   pic_width_in_luma_samples,
  input  logic [12:0]   pic_height_in_luma_samples,
  input  logic [DW-1:0] c,
  input  logic [AW:0]   c_st,
  output logic [AW-1:0] c_raddr,
  output logic          c_re_n,
  output logic [AW:0]   c_pblk,
  output logic [12:0]   c_x1,
  output logic [12:0]   c_y1,
  output logic [DW-1:0] o_data,
  output logic [10:0]   o_ux,
  output logic [10:0]   o_uy,
  output logic          o_last,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned UNIT_LOG2 = $clog2(unit);
  localparam int          CW        = $clog2(ubSize / unit) + 1;
  localparam logic [12:0] UB        = 13'(ubSize);
  localparam logic [AW:0] ONE_K     = (AW+1)'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  rd_state_e     state_q, state_d;
  logic [12:0]   w_q, h_q, x0_q, y0_q;
  logic [12:0]   x_end, y_end, nu_x, nu_y;
  logic [AW:0]   nvalid;
  logic [AW:0]   k_q;
  logic [CW-1:0] ux_q, uy_q;
  logic          in_flight_q;
  logic [22:0]   tag_q;
  logic          issue, last_read, credit;

  // Tile geometry follows the registered origin; it only moves in NEXT.
  always_comb begin
    x_end  = (x0_q + UB > w_q) ? w_q : x0_q + UB;
    y_end  = (y0_q + UB > h_q) ? h_q : y0_q + UB;
    nu_x   = ceil_div_unit(x_end - x0_q, UNIT_LOG2);
    nu_y   = ceil_div_unit(y_end - y0_q, UNIT_LOG2);
    nvalid = (AW+1)'(nu_x * nu_y);
  end

  assign last_read = (k_q == nvalid - ONE_K);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    c_pblk  = '0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (pic_width_in_luma_samples == 13'd0 || pic_height_in_luma_samples == 13'd0)
                    ? ST_FLUSH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (c_st >= nvalid) state_d = ST_READ;
      end
      ST_READ: begin
        if (credit) begin
          issue = 1'b1;
          if (last_read) begin
            c_pblk  = nvalid;
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        state_d = (x0_q + UB >= w_q && y0_q + UB >= h_q) ? ST_FLUSH : ST_WAIT;
      end
      ST_FLUSH: begin
        if (!o_valid && !in_flight_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign c_re_n  = ~issue;
  assign c_raddr = k_q[AW-1:0];
  assign busy    = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      c_x1        <= '0;
      c_y1        <= '0;
      k_q         <= '0;
      ux_q        <= '0;
      uy_q        <= '0;
      in_flight_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= issue;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            w_q  <= pic_width_in_luma_samples;
            h_q  <= pic_height_in_luma_samples;
            x0_q <= '0;
            y0_q <= '0;
          end
        end
        ST_WAIT: begin
          c_x1 <= x_end - 13'd1;
          c_y1 <= y_end - 13'd1;
          k_q  <= '0;
          ux_q <= '0;
          uy_q <= '0;
        end
        ST_READ: begin
          if (issue) begin
            k_q   <= k_q + ONE_K;
            tag_q <= {11'(x0_q >> UNIT_LOG2) + 11'(ux_q), 11'(y0_q >> UNIT_LOG2) + 11'(uy_q), last_read};
            if (13'(ux_q) == nu_x - 13'd1) begin
              ux_q <= '0;
              uy_q <= uy_q + ONE_C;
            end else begin
              ux_q <= ux_q + ONE_C;
            end
          end
        end
        ST_NEXT: begin
          if (x0_q + UB >= w_q) begin
            x0_q <= '0;
            y0_q <= y0_q + UB;
          end else begin
            x0_q <= x0_q + UB;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO data arrives one cycle after the read; the unit tag travels alongside it.
  stdcore_skid2 #(.W(DW + 23)) u_skid (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (in_flight_q),
    .push_data ({c, tag_q}),
    .in_flight (in_flight_q),
    .pop_ready (o_ready),
    .head_data ({o_data, o_ux, o_uy, o_last}),
    .head_valid(o_valid),
    .credit    (credit)
  );

endmodule

// File: doc/stdcore_ubfifo_rdctl.md
Name: stdcore_ubfifo_rdctl

Overview:
- Read-side controller placed directly downstream of the unified-block FIFO (stdcore_ubfifo).
- Walks the picture in ubSize x ubSize tiles in raster order and drives the FIFO's c_x1/c_y1 tile corners.
- Waits until the FIFO holds a full tile, reads the tile's valid unit words in sequence, and releases them with a single c_pblk commit.
- Presents the words to the next stage on a valid/ready stream tagged with unit coordinates.

Parameters:
- DW, 1, FIFO word width (one word per unit block).
- AW, 1, FIFO address width; must satisfy 2^AW >= (ubSize/unit)^2.
- ubSize, 64, unified block size in luma samples: 4, 8, 16, 32 or 64.
- unit, 4, unit block size in luma samples: 4, 8, 16 or 32; must not exceed ubSize.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE
- pic_width_in_luma_samples  in  13  picture width, sampled at start
- pic_height_in_luma_samples  in  13  picture height, sampled at start
- c  in  DW  FIFO read data, valid one cycle after c_re_n is low
- c_st  in  AW+1  FIFO stored word count
- c_raddr  out  AW  read index relative to FIFO head
- c_re_n  out  1  read enable, active low
- c_pblk  out  AW+1  commit count; nonzero only on the commit cycle
- c_x1  out  13  right pixel position of the current tile
- c_y1  out  13  bottom pixel position of the current tile
- o_data  out  DW  unit word
- o_ux  out  11  unit column in the picture
- o_uy  out  11  unit row in the picture
- o_last  out  1  last unit of the tile
- o_valid  out  1  output valid
- o_ready  in  1  downstream accept
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse after the last tile commits

Behaviour:
- Reset values: all outputs 0, except c_re_n=1; state IDLE; output buffer empty.
- Tile geometry:
  - Tile origin x0,y0 are multiples of ubSize.
  - c_x1 = min(x0+ubSize, W) - 1; c_y1 = min(y0+ubSize, H) - 1.
  - Valid units: nu_x = ceil((c_x1-x0+1)/unit), nu_y likewise; nvalid = nu_x*nu_y.
  - All arithmetic is unsigned and 13 bits wide; nvalid is AW+1 bits wide.
  - c_x1/c_y1 are registered and stable for the whole tile.
- States:
  - IDLE: busy=0. On start, latch W and H, set x0=y0=0, go to WAIT.
  - WAIT: when c_st >= nvalid, go to READ with k=0.
  - READ: issue a read (c_re_n=0, c_raddr=k) only when the output buffer will have a free slot next cycle. Read order is unit raster within the tile (ux fastest). k increments per issued read.
    - The cycle that issues read k = nvalid-1 is the commit cycle: c_pblk=nvalid that cycle only. The FIFO adds the boundary padding itself.
    - After the commit cycle go to NEXT.
  - NEXT: advance x0 by ubSize. If x0+ubSize >= W, set x0=0 and advance y0. If y0+ubSize >= H as well, go to FLUSH; otherwise go to WAIT.
  - FLUSH: when the output buffer is empty, pulse done for one cycle, then go to IDLE.
- Read pipeline:
  - Fixed latency of 1: c is captured into a 2-entry output buffer the cycle after each issued read.
  - A read may issue only if (buffer occupancy + reads in flight) < 2, or if a pop occurs in the same cycle.
  - With o_ready held high this sustains one word per cycle.
- Output stream:
  - o_valid=1 while the buffer is non-empty.
  - Transfer on o_valid & o_ready. While stalled, o_data, o_ux, o_uy and o_last are held stable.
  - o_last=1 on the tile's final unit.
  - Simultaneous push and pop keeps occupancy unchanged.
- Boundaries:
  - W or H equal to 0 at start: go straight to FLUSH; done still pulses; no reads are issued.
  - A picture not a multiple of unit uses a ceil unit count.
  - c_st is treated as monotonic non-decreasing during WAIT and READ.
- start while busy is ignored.
- arst_n asserted mid-tile: immediate return to reset values. No commit is issued, and the FIFO is expected to be reset alongside.

Decomposition:
- Shared package holds:
  - a localparam for log2(ubSize/unit);
  - the state encoding (IDLE, WAIT, READ, NEXT, FLUSH);
  - a ceil-divide-by-unit function, used for nu_x and nu_y.
- One sub-module, stdcore_skid2: the 2-entry output buffer with occupancy and a credit check.

Test Plan:
- 64x64 picture, ubSize=64, unit=4, c_st=256, o_ready=1 -> 256 reads with c_raddr 0..255 back-to-back; c_pblk=256 only on the read 255 cycle; c_x1=c_y1=63; o_last on (15,15); done pulses after the last transfer.
- 72x40 picture -> tile 0: c_x1=63, c_y1=39, nvalid=160; tile 1: c_x1=71, nvalid=20, o_ux 16..17; two commits, with c_pblk 160 then 20.
- c_st=100 held in WAIT for tile nvalid=160 -> no reads issued; c_st raised to 160 -> reads start in the next cycle.
- o_ready toggled 1 cycle on, 2 off -> no word lost or duplicated; at most 2 words buffered; c_re_n throttled; output held stable while stalled.
- 66x66 picture, unit=4 -> edge tiles have nu=1 (ceil(2/4)); 4 tiles with nvalid 256, 16, 16, 1.
- arst_n pulsed low at read 50 of a tile -> c_re_n=1, c_pblk=0, o_valid=0 immediately; a fresh start replays from tile (0,0).
